// File: rtl/map_pkg.sv
// Shared constants for the tile-map writer: tile codes, event kinds,
// FSM state encodings and the level-start layout.
package map_pkg;

  localparam int DEF_ROWS = 13;
  localparam int DEF_COLS = 64;

  localparam logic [3:0] TILE_AIR      = 4'h0;
  localparam logic [3:0] TILE_QUESTION = 4'h1;
  localparam logic [3:0] TILE_COIN     = 4'h2;
  localparam logic [3:0] TILE_USED     = 4'h3;

  localparam logic KIND_HIT   = 1'b0;
  localparam logic KIND_TOUCH = 1'b1;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;
  localparam logic [1:0] ST_WR   = 2'd3;

  // Level-start layout: a band of coin rows, then a row of spaced question blocks.
  localparam int COIN_ROW_FIRST = 2;
  localparam int COIN_ROW_LAST  = 6;
  localparam int QUESTION_ROW   = 7;
  localparam int QUESTION_PITCH = 4;

endpackage

// File: rtl/map_init_rom.sv
// Combinational level-start content: maps a row-major tile address to the
// tile the level begins with.
module map_init_rom
  import map_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int AW   = 10
) (
  input  logic [AW-1:0] addr,
  output logic [3:0]    tile
);

  logic [AW-1:0] row;
  logic [AW-1:0] col;

  always_comb begin
    row  = addr / AW'(COLS);
    col  = addr % AW'(COLS);
    tile = TILE_AIR;
    if (row >= AW'(COIN_ROW_FIRST) && row <= AW'(COIN_ROW_LAST)) begin
      tile = TILE_COIN;
    end else if (row == AW'(QUESTION_ROW) && (col % AW'(QUESTION_PITCH)) == '0) begin
      tile = TILE_QUESTION;
    end
  end

endmodule

// File: rtl/map_tile_writer.sv
// Tile map with an init sweep, a read-modify-write event port that awards
// coins, and a one-cycle-latency renderer read port.
module map_tile_writer
  import map_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ievt_valid,
  output logic       oevt_ready,
  input  logic [5:0] ievt_x,
  input  logic [3:0] ievt_y,
  input  logic       ievt_kind,
  input  logic [5:0] irx,
  input  logic [3:0] iry,
  output logic [3:0] ortile,
  output logic       oaward,
  output logic       oerr,
  output logic [7:0] ocoins,
  output logic       obusy
);

  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] init_cnt_q, init_cnt_d;
  logic [5:0]    ev_x_q, ev_x_d;
  logic [3:0]    ev_y_q, ev_y_d;
  logic          ev_kind_q, ev_kind_d;
  logic          award_q, award_d;
  logic          err_q, err_d;
  logic [7:0]    coins_q, coins_d;
  logic          rzero_q, rzero_d;

  logic [3:0]    mem [DEPTH];
  logic [3:0]    ev_rdata;
  logic [3:0]    r_rdata;
  logic [3:0]    rom_tile;
  logic          ev_ok, r_ok, ev_re, mem_we;
  logic [AW-1:0] ev_addr, r_addr, mem_waddr;
  logic [3:0]    mem_wdata;

  map_init_rom #(.COLS(COLS), .AW(AW)) u_rom (
    .addr (init_cnt_q),
    .tile (rom_tile)
  );

  // Out-of-range coordinates are forced to address 0 so no access strays past the RAM.
  always_comb begin
    ev_ok   = (int'(ev_x_q) < COLS) && (int'(ev_y_q) < ROWS);
    r_ok    = (int'(irx) < COLS) && (int'(iry) < ROWS);
    ev_addr = ev_ok ? (AW'(ev_y_q) * AW'(COLS) + AW'(ev_x_q)) : '0;
    r_addr  = r_ok ? (AW'(iry) * AW'(COLS) + AW'(irx)) : '0;
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ev_x_d     = ev_x_q;
    ev_y_d     = ev_y_q;
    ev_kind_d  = ev_kind_q;
    award_d    = 1'b0;
    err_d      = 1'b0;
    coins_d    = coins_q;
    ev_re      = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = init_cnt_q;
    mem_wdata  = rom_tile;
    case (state_q)
      ST_INIT: begin
        mem_we = 1'b1;
        if (init_cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (ievt_valid) begin
          ev_x_d    = ievt_x;
          ev_y_d    = ievt_y;
          ev_kind_d = ievt_kind;
          state_d   = ST_RD;
        end
      end
      ST_RD: begin
        ev_re   = ev_ok;
        state_d = ST_WR;
      end
      ST_WR: begin
        state_d = ST_IDLE;
        if (!ev_ok) begin
          err_d = 1'b1;
        end else if (ev_kind_q == KIND_HIT && ev_rdata == TILE_QUESTION) begin
          mem_we    = 1'b1;
          mem_waddr = ev_addr;
          mem_wdata = TILE_USED;
          award_d   = 1'b1;
        end else if (ev_kind_q == KIND_TOUCH && ev_rdata == TILE_COIN) begin
          mem_we    = 1'b1;
          mem_waddr = ev_addr;
          mem_wdata = TILE_AIR;
          award_d   = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
    if (award_d && coins_q != 8'hFF) begin
      coins_d = coins_q + 8'd1;
    end
    // A reset edge must never commit a pending sweep or event write.
    if (rst) begin
      mem_we = 1'b0;
    end
    rzero_d = (state_q == ST_INIT) || !r_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      ev_x_q     <= '0;
      ev_y_q     <= '0;
      ev_kind_q  <= 1'b0;
      award_q    <= 1'b0;
      err_q      <= 1'b0;
      coins_q    <= '0;
      rzero_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ev_x_q     <= ev_x_d;
      ev_y_q     <= ev_y_d;
      ev_kind_q  <= ev_kind_d;
      award_q    <= award_d;
      err_q      <= err_d;
      coins_q    <= coins_d;
      rzero_q    <= rzero_d;
    end
  end

  // Both read ports return the pre-write value when they hit the address being written.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (ev_re) begin
      ev_rdata <= mem[ev_addr];
    end
    r_rdata <= mem[r_addr];
  end

  assign oevt_ready = (state_q == ST_IDLE);
  assign obusy      = (state_q == ST_INIT);
  assign ortile     = rzero_q ? TILE_AIR : r_rdata;
  assign oaward     = award_q;
  assign oerr       = err_q;
  assign ocoins     = coins_q;

endmodule

// File: tb/tb_map_tile_writer.sv
// Directed self-checking bench for map_tile_writer: init sweep, coin awards,
// out-of-range events, reset abandonment and coin saturation.
module tb_map_tile_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       ievt_valid;
  logic       oevt_ready;
  logic [5:0] ievt_x;
  logic [3:0] ievt_y;
  logic       ievt_kind;
  logic [5:0] irx;
  logic [3:0] iry;
  logic [3:0] ortile;
  logic       oaward;
  logic       oerr;
  logic [7:0] ocoins;
  logic       obusy;

  int vectors     = 0;
  int miscompares = 0;

  logic       ev_aw2, ev_aw3, ev_err3, ev_rdy_mid, ev_rdy3;
  logic [7:0] ev_c3;
  logic [3:0] ev_rt3;
  logic [3:0] rd_tile;

  map_tile_writer dut (
    .clk        (clk),
    .rst        (rst),
    .ievt_valid (ievt_valid),
    .oevt_ready (oevt_ready),
    .ievt_x     (ievt_x),
    .ievt_y     (ievt_y),
    .ievt_kind  (ievt_kind),
    .irx        (irx),
    .iry        (iry),
    .ortile     (ortile),
    .oaward     (oaward),
    .oerr       (oerr),
    .ocoins     (ocoins),
    .obusy      (obusy)
  );

  always #5 clk = ~clk;

  // Issues one event at the next ready cycle T and returns at the negedge of T+3.
  // The renderer reads the event address in T+2, the same cycle as the write.
  task automatic send_event(input logic [5:0] x, input logic [3:0] y, input logic k);
    int n = 0;
    while (!oevt_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!oevt_ready) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL ready_timeout: oevt_ready stayed 0 for %0d cycles, want 1", n);
    end
    ievt_valid = 1'b1;
    ievt_x     = x;
    ievt_y     = y;
    ievt_kind  = k;
    @(negedge clk);
    ievt_valid = 1'b0;
    ievt_x     = ~x;
    ievt_y     = ~y;
    ievt_kind  = ~k;
    ev_rdy_mid = oevt_ready;
    @(negedge clk);
    ev_aw2     = oaward;
    ev_rdy_mid = ev_rdy_mid | oevt_ready;
    irx        = x;
    iry        = y;
    @(negedge clk);
    ev_aw3  = oaward;
    ev_err3 = oerr;
    ev_rdy3 = oevt_ready;
    ev_c3   = ocoins;
    ev_rt3  = ortile;
  endtask

  task automatic read_tile(input logic [5:0] x, input logic [3:0] y);
    irx = x;
    iry = y;
    @(negedge clk);
    rd_tile = ortile;
  endtask

  task automatic test_reset;
    int busy_cnt = 0;
    rst        = 1'b1;
    ievt_valid = 1'b0;
    ievt_x     = '0;
    ievt_y     = '0;
    ievt_kind  = 1'b0;
    irx        = 6'd14;
    iry        = 4'd2;
    repeat (3) @(negedge clk);
    vectors++; if (ortile !== 4'h0) begin miscompares++; $display("[TB] FAIL rst_ortile: got %0h want 0", ortile); end
    vectors++; if (ocoins !== 8'h00) begin miscompares++; $display("[TB] FAIL rst_ocoins: got %0d want 0", ocoins); end
    vectors++; if (oaward !== 1'b0 || oerr !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_pulses: got aw=%0b err=%0b want 0 0", oaward, oerr); end
    vectors++; if (obusy !== 1'b1 || oevt_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy: got busy=%0b ready=%0b want 1 0", obusy, oevt_ready); end
    rst = 1'b0;
    // A HIT on a question block held during the sweep must be ignored.
    ievt_valid = 1'b1;
    ievt_x     = 6'd8;
    ievt_y     = 4'd7;
    ievt_kind  = 1'b0;
    while (obusy === 1'b1 && busy_cnt < 2000) begin
      if (busy_cnt == 100) ievt_valid = 1'b0;
      if (busy_cnt == 400) begin
        vectors++; if (ortile !== 4'h0) begin miscompares++; $display("[TB] FAIL busy_ortile: got %0h want 0", ortile); end
      end
      busy_cnt++;
      @(negedge clk);
    end
    vectors++; if (busy_cnt != 832) begin miscompares++; $display("[TB] FAIL busy_cycles: got %0d want 832", busy_cnt); end
    vectors++; if (oevt_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL idle_ready: got %0b want 1", oevt_ready); end
  endtask

  task automatic test_init_content;
    read_tile(6'd14, 4'd2);
    vectors++; if (rd_tile !== 4'h2) begin miscompares++; $display("[TB] FAIL init_14_2: got %0h want 2", rd_tile); end
    read_tile(6'd8, 4'd7);
    vectors++; if (rd_tile !== 4'h1) begin miscompares++; $display("[TB] FAIL init_8_7: got %0h want 1", rd_tile); end
    read_tile(6'd9, 4'd7);
    vectors++; if (rd_tile !== 4'h0) begin miscompares++; $display("[TB] FAIL init_9_7: got %0h want 0", rd_tile); end
    read_tile(6'd0, 4'd0);
    vectors++; if (rd_tile !== 4'h0) begin miscompares++; $display("[TB] FAIL init_0_0: got %0h want 0", rd_tile); end
    read_tile(6'd63, 4'd6);
    vectors++; if (rd_tile !== 4'h2) begin miscompares++; $display("[TB] FAIL init_63_6: got %0h want 2", rd_tile); end
    read_tile(6'd14, 4'd13);
    vectors++; if (rd_tile !== 4'h0) begin miscompares++; $display("[TB] FAIL oob_read: got %0h want 0", rd_tile); end
    vectors++; if (ocoins !== 8'd0) begin miscompares++; $display("[TB] FAIL ignored_event: got coins %0d want 0", ocoins); end
  endtask

  task automatic test_hit;
    send_event(6'd8, 4'd7, 1'b0);
    vectors++; if (ev_rdy_mid !== 1'b0) begin miscompares++; $display("[TB] FAIL hit_ready_busy: got %0b want 0", ev_rdy_mid); end
    vectors++; if (ev_aw2 !== 1'b0) begin miscompares++; $display("[TB] FAIL hit_award_early: got %0b want 0", ev_aw2); end
    vectors++; if (ev_aw3 !== 1'b1 || ev_err3 !== 1'b0) begin miscompares++; $display("[TB] FAIL hit_award: got aw=%0b err=%0b want 1 0", ev_aw3, ev_err3); end
    vectors++; if (ev_c3 !== 8'd1) begin miscompares++; $display("[TB] FAIL hit_coins: got %0d want 1", ev_c3); end
    vectors++; if (ev_rdy3 !== 1'b1) begin miscompares++; $display("[TB] FAIL hit_ready_t3: got %0b want 1", ev_rdy3); end
    vectors++; if (ev_rt3 !== 4'h1) begin miscompares++; $display("[TB] FAIL hit_read_old: got %0h want 1", ev_rt3); end
    read_tile(6'd8, 4'd7);
    vectors++; if (rd_tile !== 4'h3) begin miscompares++; $display("[TB] FAIL hit_tile: got %0h want 3", rd_tile); end
    vectors++; if (oaward !== 1'b0) begin miscompares++; $display("[TB] FAIL hit_pulse_len: got %0b want 0", oaward); end
  endtask

  task automatic test_second_hit;
    send_event(6'd8, 4'd7, 1'b0);
    vectors++; if (ev_aw3 !== 1'b0) begin miscompares++; $display("[TB] FAIL rehit_award: got %0b want 0", ev_aw3); end
    vectors++; if (ev_c3 !== 8'd1) begin miscompares++; $display("[TB] FAIL rehit_coins: got %0d want 1", ev_c3); end
    read_tile(6'd8, 4'd7);
    vectors++; if (rd_tile !== 4'h3) begin miscompares++; $display("[TB] FAIL rehit_tile: got %0h want 3", rd_tile); end
  endtask

  task automatic test_touch;
    send_event(6'd14, 4'd6, 1'b1);
    vectors++; if (ev_aw3 !== 1'b1 || ev_c3 !== 8'd2) begin miscompares++; $display("[TB] FAIL touch_coin: got aw=%0b coins=%0d want 1 2", ev_aw3, ev_c3); end
    read_tile(6'd14, 4'd6);
    vectors++; if (rd_tile !== 4'h0) begin miscompares++; $display("[TB] FAIL touch_coin_tile: got %0h want 0", rd_tile); end
    send_event(6'd0, 4'd0, 1'b1);
    vectors++; if (ev_aw3 !== 1'b0 || ev_c3 !== 8'd2) begin miscompares++; $display("[TB] FAIL touch_air: got aw=%0b coins=%0d want 0 2", ev_aw3, ev_c3); end
    read_tile(6'd0, 4'd0);
    vectors++; if (rd_tile !== 4'h0) begin miscompares++; $display("[TB] FAIL touch_air_tile: got %0h want 0", rd_tile); end
    send_event(6'd20, 4'd4, 1'b0);
    vectors++; if (ev_aw3 !== 1'b0) begin miscompares++; $display("[TB] FAIL hit_coin: got aw=%0b want 0", ev_aw3); end
    read_tile(6'd20, 4'd4);
    vectors++; if (rd_tile !== 4'h2) begin miscompares++; $display("[TB] FAIL hit_coin_tile: got %0h want 2", rd_tile); end
    send_event(6'd12, 4'd7, 1'b1);
    vectors++; if (ev_aw3 !== 1'b0) begin miscompares++; $display("[TB] FAIL touch_question: got aw=%0b want 0", ev_aw3); end
    read_tile(6'd12, 4'd7);
    vectors++; if (rd_tile !== 4'h1) begin miscompares++; $display("[TB] FAIL touch_question_tile: got %0h want 1", rd_tile); end
  endtask

  task automatic test_out_of_range;
    send_event(6'd8, 4'd13, 1'b1);
    vectors++; if (ev_err3 !== 1'b1 || ev_aw3 !== 1'b0) begin miscompares++; $display("[TB] FAIL oob_event: got err=%0b aw=%0b want 1 0", ev_err3, ev_aw3); end
    vectors++; if (ev_c3 !== 8'd2) begin miscompares++; $display("[TB] FAIL oob_coins: got %0d want 2", ev_c3); end
    vectors++; if (ev_rdy3 !== 1'b1) begin miscompares++; $display("[TB] FAIL oob_ready: got %0b want 1", ev_rdy3); end
    read_tile(6'd8, 4'd12);
    vectors++; if (oerr !== 1'b0) begin miscompares++; $display("[TB] FAIL oob_pulse_len: got %0b want 0", oerr); end
    vectors++; if (rd_tile !== 4'h0) begin miscompares++; $display("[TB] FAIL oob_tile: got %0h want 0", rd_tile); end
    send_event(6'd4, 4'd15, 1'b0);
    vectors++; if (ev_err3 !== 1'b1 || ev_c3 !== 8'd2) begin miscompares++; $display("[TB] FAIL oob_y15: got err=%0b coins=%0d want 1 2", ev_err3, ev_c3); end
  endtask

  task automatic test_reset_mid_event;
    int n = 0;
    logic saw_award = 1'b0;
    while (!oevt_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    ievt_valid = 1'b1;
    ievt_x     = 6'd12;
    ievt_y     = 4'd7;
    ievt_kind  = 1'b0;
    @(negedge clk);
    ievt_valid = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (obusy !== 1'b1 || ocoins !== 8'd0) begin miscompares++; $display("[TB] FAIL midrst_state: got busy=%0b coins=%0d want 1 0", obusy, ocoins); end
    n = 0;
    while (obusy === 1'b1 && n < 2000) begin
      saw_award = saw_award | oaward;
      n++;
      @(negedge clk);
    end
    vectors++; if (obusy !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_timeout: got busy=%0b after %0d cycles want 0", obusy, n); end
    vectors++; if (saw_award !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_award: got %0b want 0", saw_award); end
    read_tile(6'd12, 4'd7);
    vectors++; if (rd_tile !== 4'h1) begin miscompares++; $display("[TB] FAIL midrst_tile: got %0h want 1", rd_tile); end
    vectors++; if (ocoins !== 8'd0) begin miscompares++; $display("[TB] FAIL midrst_coins: got %0d want 0", ocoins); end
  endtask

  task automatic test_saturation;
    int awards = 0;
    logic [7:0] c253 = '0, c254 = '0, c255 = '0, c256 = '0;
    logic aw256 = 1'b0;
    for (int i = 0; i < 257; i++) begin
      send_event(6'(i % 64), 4'(2 + i / 64), 1'b1);
      if (ev_aw3 === 1'b1) awards++;
      if (i == 253) c253 = ev_c3;
      if (i == 254) c254 = ev_c3;
      if (i == 255) c255 = ev_c3;
      if (i == 256) begin c256 = ev_c3; aw256 = ev_aw3; end
    end
    vectors++; if (awards != 257) begin miscompares++; $display("[TB] FAIL sat_awards: got %0d want 257", awards); end
    vectors++; if (c253 !== 8'd254) begin miscompares++; $display("[TB] FAIL sat_254: got %0d want 254", c253); end
    vectors++; if (c254 !== 8'd255) begin miscompares++; $display("[TB] FAIL sat_255: got %0d want 255", c254); end
    vectors++; if (c255 !== 8'd255 || c256 !== 8'd255) begin miscompares++; $display("[TB] FAIL sat_hold: got %0d %0d want 255 255", c255, c256); end
    vectors++; if (aw256 !== 1'b1) begin miscompares++; $display("[TB] FAIL sat_pulse: got %0b want 1", aw256); end
  endtask

  initial begin
    test_reset();
    test_init_content();
    test_hit();
    test_second_hit();
    test_touch();
    test_out_of_range();
    test_reset_mid_event();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/map_tile_writer.md
MAP_TILE_WRITER -- requirements
Module: map_tile_writer

Interface
REQ-001 The module SHALL have parameter ROWS, default 13, meaning the number of map rows.
REQ-002 The module SHALL have parameter COLS, default 64, meaning the number of map columns.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 The module SHALL have port ievt_valid, input, 1 bit: a player-event request is present.
REQ-006 The module SHALL have port oevt_ready, output, 1 bit: an event is accepted in any cycle where ievt_valid and oevt_ready are both 1.
REQ-007 The module SHALL have ports ievt_x (input, 6 bits, column), ievt_y (input, 4 bits, row) and ievt_kind (input, 1 bit: 0 = HIT from below, 1 = TOUCH).
REQ-008 The module SHALL have ports irx (input, 6 bits) and iry (input, 4 bits): the renderer read address.
REQ-009 The module SHALL have port ortile, output, 4 bits: the tile code at the renderer address.
REQ-010 The module SHALL have port oaward, output, 1 bit: a one-cycle pulse when a coin is awarded.
REQ-011 The module SHALL have port oerr, output, 1 bit: a one-cycle pulse when an out-of-range event is consumed.
REQ-012 The module SHALL have port ocoins, output, 8 bits: the saturating coin count.
REQ-013 The module SHALL have port obusy, output, 1 bit: high while the map initialisation sweep runs.

Function
REQ-014 Tile codes SHALL be 4 bits: AIR = 4'h0, QUESTION = 4'h1, COIN = 4'h2, USED = 4'h3.
REQ-015 The tile store SHALL be a ROWS*COLS x 4-bit RAM with two ports: the event read/write port and the renderer read-only port.
REQ-016 The FSM SHALL have four states, INIT, IDLE, RD and WR, with oevt_ready = 1 only in IDLE.
REQ-017 INIT SHALL write the level-start tile for every address, row-major from (0,0), one address per cycle, and SHALL take exactly ROWS*COLS cycles.
REQ-018 After the last INIT write, the FSM SHALL go to IDLE; obusy SHALL equal 1 exactly while in INIT.
REQ-019 An event accepted in cycle T SHALL be latched, with RD in cycle T+1 and WR in cycle T+2, and oevt_ready SHALL be 1 again in cycle T+3.
REQ-020 In WR, a HIT on QUESTION SHALL write USED and award one coin.
REQ-021 In WR, a TOUCH on COIN SHALL write AIR and award one coin.
REQ-022 All other kind/tile combinations SHALL perform no write and no award.
REQ-023 oaward SHALL be registered: high for one cycle in T+3, with ocoins incremented in the same cycle.
REQ-024 ocoins SHALL saturate at 255: an award at 255 still pulses oaward, and the count stays 255.
REQ-025 An event with ievt_y >= ROWS or ievt_x >= COLS SHALL be consumed normally but make no RAM access, give no award, and pulse oerr in T+3.
REQ-026 ortile SHALL have one-cycle latency from irx/iry.
REQ-027 ortile SHALL read 4'h0 while obusy = 1 and for any out-of-range renderer address.
REQ-028 When the renderer reads an address in the cycle that address is written, ortile SHALL return the old value; the new value SHALL be visible on the next read.
REQ-029 ievt_valid while oevt_ready = 0 SHALL be ignored (the event is not queued), and the event fields SHALL be sampled only at acceptance.

Reset
REQ-030 rst SHALL force state INIT, restart the sweep at address 0, and clear ocoins, oaward, oerr and ortile to 0 on the next edge.
REQ-031 rst asserted mid-INIT or mid-event SHALL abandon the pending operation: no write, no award.

Structure
REQ-032 The tile codes, event-kind codes and the ROWS/COLS defaults SHALL live in the shared package map_pkg.
REQ-033 The level-start content SHALL come from a combinational sub-module map_init_rom (address in, 4-bit tile out) driven by the INIT sweep counter.

Verification
REQ-034 Reset then idle -> obusy high for exactly 832 cycles; then read (x=14,y=2) -> ortile = COIN.
REQ-035 HIT at (8,7), a QUESTION tile, accepted at T -> oaward high at T+3, ocoins = 1, and a later read of (8,7) = USED.
REQ-036 A second HIT at (8,7) -> no oaward, and the tile stays USED.
REQ-037 TOUCH at (14,6), a COIN tile -> award, then the tile reads AIR; a TOUCH on AIR at (0,0) -> nothing.
REQ-038 Event at y=13 -> oerr pulse at T+3, no write, and ocoins unchanged; 256 awards -> ocoins = 255.
REQ-039 rst asserted in cycle T+1 of a HIT -> tile unchanged after re-init, ocoins = 0.
